// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle control FSM.
//   - state encoding (FETCH..WB)
//   - opcode / funct constants of the supported MIPS subset
//   - encodings of the pc_sel, reg_dst, wd_sel and alu_op selects
//   - one-hot instruction class produced by mc_decode
package mc_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;

    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSubu  = 6'h23;
    localparam logic [5:0] FnJr    = 6'h08;

    localparam logic [1:0] PcPlus4  = 2'd0;
    localparam logic [1:0] PcBranch = 2'd1;
    localparam logic [1:0] PcJump   = 2'd2;
    localparam logic [1:0] PcReg    = 2'd3;

    localparam logic [1:0] DstRt    = 2'd0;
    localparam logic [1:0] DstRd    = 2'd1;
    localparam logic [1:0] DstRa    = 2'd2;

    localparam logic [1:0] WdAlu    = 2'd0;
    localparam logic [1:0] WdMem    = 2'd1;
    localparam logic [1:0] WdPc     = 2'd2;

    localparam logic [2:0] AluAdd   = 3'd0;
    localparam logic [2:0] AluSub   = 3'd1;
    localparam logic [2:0] AluOr    = 3'd2;
    localparam logic [2:0] AluLui   = 3'd3;

    // One-hot instruction class; all-zero means unknown (executes as nop).
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction classifier.
//   opcode  in  6   IR[31:26]
//   funct   in  6   IR[5:0]
//   iclass  out     one-hot instruction class (all zero = unknown)
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass
);

    always_comb begin
        iclass = '0;
        case (opcode)
            OpRtype: begin
                case (funct)
                    FnAddu:  iclass.addu = 1'b1;
                    FnSubu:  iclass.subu = 1'b1;
                    FnJr:    iclass.jr   = 1'b1;
                    default: ;
                endcase
            end
            OpOri:   iclass.ori = 1'b1;
            OpLui:   iclass.lui = 1'b1;
            OpLw:    iclass.lw  = 1'b1;
            OpSw:    iclass.sw  = 1'b1;
            OpBeq:   iclass.beq = 1'b1;
            OpJ:     iclass.j   = 1'b1;
            OpJal:   iclass.jal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS subset core.
//   clk, reset (sync, active-high)
//   opcode, funct, zero          : registered IR fields and ALU zero flag
//   pc_we, pc_sel, ir_we         : PC / IR control
//   reg_we, reg_dst, wd_sel      : register file write control
//   alu_op, alu_src_b, ext_op    : ALU / immediate control
//   mem_we                       : data memory write enable
//   instr_done                   : pulse on the last state of each instruction
//   state                        : current FSM state (debug)
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       ir_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic [2:0] alu_op,
    output logic       alu_src_b,
    output logic       ext_op,
    output logic       mem_we,
    output logic       instr_done,
    output logic [2:0] state
);

    state_e  state_q, state_d;
    iclass_t cls;

    logic alu_class;   // result written back from the ALU
    logic rtype;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .iclass (cls)
    );

    assign rtype     = cls.addu | cls.subu;
    assign alu_class = rtype | cls.ori | cls.lui;
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: if (alu_class | cls.lw | cls.sw | cls.beq) state_d = StExec;
            StExec: begin
                if (alu_class)           state_d = StWb;
                else if (cls.lw | cls.sw) state_d = StMem;
            end
            StMem:    if (cls.lw) state_d = StWb;
            default:  state_d = StFetch;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        pc_sel     = PcPlus4;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = DstRt;
        wd_sel     = WdAlu;
        alu_op     = AluAdd;
        alu_src_b  = 1'b0;
        ext_op     = 1'b0;
        mem_we     = 1'b0;

        // ALU/address selects hold from EXEC through MEM and WB.
        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            unique case (1'b1)
                cls.subu: alu_op = AluSub;
                cls.beq:  alu_op = AluSub;
                cls.ori:  begin alu_op = AluOr;  alu_src_b = 1'b1; end
                cls.lui:  begin alu_op = AluLui; alu_src_b = 1'b1; end
                cls.lw,
                cls.sw:   begin alu_op = AluAdd; alu_src_b = 1'b1; ext_op = 1'b1; end
                default:  alu_op = AluAdd;
            endcase
        end

        case (state_q)
            StFetch: begin
                ir_we = 1'b1;
                pc_we = 1'b1;
            end
            StDecode: begin
                if (cls.j | cls.jal) begin
                    pc_we  = 1'b1;
                    pc_sel = PcJump;
                end
                if (cls.jal) begin
                    // Datapath PC already holds PC+4 here, which is the link value.
                    reg_we  = 1'b1;
                    reg_dst = DstRa;
                    wd_sel  = WdPc;
                end
                if (cls.jr) begin
                    pc_we  = 1'b1;
                    pc_sel = PcReg;
                end
            end
            StExec: begin
                if (cls.beq) begin
                    pc_sel = PcBranch;
                    pc_we  = zero;
                end
            end
            StMem: mem_we = cls.sw;
            StWb: begin
                reg_we  = alu_class | cls.lw;
                reg_dst = rtype  ? DstRd : DstRt;
                wd_sel  = cls.lw ? WdMem : WdAlu;
            end
            default: ;
        endcase

        instr_done = (state_q != StFetch) && (state_d == StFetch);

        // Nothing may be written while reset is held, including an aborted instruction.
        if (reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            mem_we     = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS subset core. It sequences the shared datapath (PC register, instruction register, register file, ALU, data memory) one instruction at a time, across 2–5 states. It sits beside the datapath and drives all write enables and mux selects. It consumes only the registered instruction fields and the ALU zero flag.

## Interface
Parameters: none.

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; state forced to FETCH
- opcode  in  6  IR[31:26], registered instruction field
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0, from the current EXEC cycle
- pc_we  out  1  PC register load enable
- pc_sel  out  2  next-PC source: 0 PC+4, 1 branch target, 2 jump target (j/jal), 3 GPR[rs] (jr)
- ir_we  out  1  instruction register load enable
- reg_we  out  1  register file write enable
- reg_dst  out  2  write address: 0 rt, 1 rd, 2 $31
- wd_sel  out  2  write data: 0 ALU result, 1 memory read data, 2 current PC
- alu_op  out  3  0 ADD, 1 SUB, 2 OR, 3 LUI (imm<<16)
- alu_src_b  out  1  0 GPR[rt], 1 extended immediate
- ext_op  out  1  0 zero-extend, 1 sign-extend
- mem_we  out  1  data memory write enable
- instr_done  out  1  one-cycle pulse on the last state of each instruction
- state  out  3  current state, for debug and bench

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH: ir_we=1, pc_we=1, pc_sel=0. Next state is DECODE.
- DECODE: instruction class is taken from opcode/funct.
  - j: pc_we=1, pc_sel=2, then FETCH.
  - jal: pc_we=1, pc_sel=2, reg_we=1, reg_dst=2, wd_sel=2. The PC value written is already PC+4. Then FETCH.
  - jr (opcode 0, funct 0x08): pc_we=1, pc_sel=3, then FETCH.
  - Unknown opcode or funct: no enables asserted, then FETCH (executes as nop).
  - All other classes go to EXEC.
- EXEC:
  - addu/subu: alu_src_b=0, alu_op ADD/SUB, then WB.
  - ori: alu_src_b=1, ext_op=0, alu_op OR, then WB.
  - lui: alu_src_b=1, alu_op LUI, then WB.
  - lw/sw: alu_src_b=1, ext_op=1, alu_op ADD, then MEM.
  - beq: alu_src_b=0, alu_op SUB, pc_sel=1, pc_we=zero, then FETCH.
- MEM: lw goes to WB. sw asserts mem_we=1 and goes to FETCH.
- WB: reg_we=1, then FETCH.
  - R-type: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
- Datapath selects keep their EXEC values through MEM and WB, so the ALU and address paths stay stable.
- instr_done is asserted on the transition back to FETCH.
- All outputs are combinational from state, opcode, funct and zero. Unlisted outputs are 0.

## Timing
- Cycles per instruction: j/jal/jr/nop 2, beq 3, R-type/ori/lui/sw 4, lw 5.
- Reset: state=FETCH on the next edge. While reset=1, all enables (pc_we, ir_we, reg_we, mem_we, instr_done) are forced 0.
- First fetch occurs in the cycle after reset deasserts.
- Reset mid-instruction aborts it; no write of that instruction occurs after the reset edge.
- opcode/funct are ignored in FETCH because IR is being loaded. They are valid from DECODE onward.
- zero is sampled only in beq EXEC.
- jal: the PC and $31 writes happen on the same edge.

## Structure
- Package mc_pkg holds:
  - state encoding (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4);
  - opcode constants (R=0x00, ori=0x0D, lui=0x0F, lw=0x23, sw=0x2B, beq=0x04, j=0x02, jal=0x03);
  - funct constants (addu=0x21, subu=0x23, jr=0x08);
  - pc_sel, reg_dst, wd_sel and alu_op encodings.
- Sub-module mc_decode: purely combinational. Maps opcode/funct to a one-hot instruction class. mc_ctrl holds the state register and output logic.

## Test plan
- Assert reset for 2 cycles, then release → state=FETCH, all enables 0 during reset; ir_we=pc_we=1 in the first cycle after release.
- addu (op 0, funct 0x21) → states FETCH, DECODE, EXEC, WB; WB has reg_we=1, reg_dst=1; instr_done pulses on cycle 4.
- lw (0x23), then sw (0x2B) → lw takes 5 cycles with wd_sel=1 in WB. sw has mem_we=1 only in MEM and reg_we never asserts.
- beq with zero=1, then with zero=0 → pc_we=1, pc_sel=1 in EXEC for the first; pc_we=0 for the second; both take 3 cycles.
- jal (0x03), then opcode 0x3F → jal in DECODE: pc_we=reg_we=1, reg_dst=2, wd_sel=2. 0x3F: 2 cycles with no enables asserted.
- Assert reset in the MEM state of sw → mem_we=0 that cycle; state=FETCH next cycle.
